// File: rtl/tbcm_mux_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream between ENTRIES requesters.
// The grant is held from the first beat of a packet through the beat flagged last.
module tbcm_mux_arbiter #(
    parameter int unsigned WIDTH     = 2,
    parameter type         DATA_TYPE = logic [WIDTH-1:0],
    parameter int unsigned ENTRIES   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [ENTRIES-1:0] i_valid,
    output logic [ENTRIES-1:0] o_ready,
    input  DATA_TYPE           i_data [ENTRIES],
    input  logic [ENTRIES-1:0] i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output DATA_TYPE           o_data,
    output logic               o_last,
    output logic [ENTRIES-1:0] o_grant
);

    localparam int unsigned INDEX_WIDTH = $clog2(ENTRIES);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] ptr_n;
    logic [ENTRIES-1:0]     grant_q;
    logic [ENTRIES-1:0]     grant_n;

    logic [ENTRIES-1:0]     grant_c;
    logic [INDEX_WIDTH-1:0] win_hi;
    logic [INDEX_WIDTH-1:0] win_lo;
    logic                   found_hi;
    logic                   found_any;
    logic [INDEX_WIDTH-1:0] sel_idx;
    logic [INDEX_WIDTH-1:0] ptr_adv;
    logic                   xfer;
    logic                   eop;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid index overall.
    always_comb begin
        win_hi    = '0;
        win_lo    = '0;
        found_hi  = 1'b0;
        found_any = 1'b0;
        grant_c   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (i_valid[i] && !found_any) begin
                win_lo    = INDEX_WIDTH'(i);
                found_any = 1'b1;
            end
            if (i_valid[i] && !found_hi && (32'(i) >= 32'(ptr))) begin
                win_hi   = INDEX_WIDTH'(i);
                found_hi = 1'b1;
            end
        end
        if (found_any) begin
            grant_c = ENTRIES'(1) << (found_hi ? win_hi : win_lo);
        end
    end

    // State register: asynchronous clear drops any in-flight packet lock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            grant_q <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            grant_q <= grant_n;
        end
    end

    // Next state: lock on any presented beat that is not an end of packet, release on eop.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant_q;
        case (state)
            IDLE: begin
                if (eop) begin
                    ptr_n = ptr_adv;
                end else if (o_valid) begin
                    state_n = LOCKED;
                    grant_n = grant_c;
                end
            end
            LOCKED: begin
                if (eop) begin
                    state_n = IDLE;
                    ptr_n   = ptr_adv;
                    grant_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs: one-hot select mux steered by the live pick or the frozen grant.
    always_comb begin
        o_grant = (state == LOCKED) ? grant_q : grant_c;
        o_data  = '0;
        o_last  = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (o_grant[i]) begin
                o_data  = i_data[i];
                o_last  = i_last[i];
                sel_idx = INDEX_WIDTH'(i);
            end
        end
        o_valid = |(i_valid & o_grant);
        o_ready = i_ready ? o_grant : '0;
        xfer    = o_valid & i_ready;
        eop     = xfer & o_last;
        ptr_adv = (sel_idx == INDEX_WIDTH'(ENTRIES - 1)) ? '0 : sel_idx + INDEX_WIDTH'(1);
    end

endmodule
